// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for an LDPC decoder: sequences load, check-node and variable-node phases per frame.
// Optional early termination on satisfied parity is enabled by defining LDPC_EARLY_TERM_EN.
module ldpc_iter_ctrl #(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              i_val,
    output logic              i_rdy,
    output logic              load_en,
    output logic              cn_start,
    input  logic              cn_done,
    output logic              vn_start,
    input  logic              vn_done,
    input  logic              parity,
    output logic              o_val,
    input  logic              o_rdy,
    output logic              o_fail,
    output logic [ITER_W-1:0] roop
);

    typedef enum logic [2:0] {IDLE, LOAD, CN, VN, CHK, OUT} state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

    state_t            state;
    state_t            state_nxt;
    logic              ready_q;
    logic              last_iter;
    logic [ITER_W-1:0] roop_inc;

    assign roop_inc = roop + ITER_W'(1);

`ifdef LDPC_EARLY_TERM_EN
    assign last_iter = (roop_inc == MAX_ITER_V) || parity;
`else
    assign last_iter = (roop_inc == MAX_ITER_V);
`endif

    // ready_q keeps i_rdy low while reset is held even though state already sits in IDLE
    assign i_rdy   = ready_q && (state == IDLE);
    assign load_en = (state == LOAD);
    assign o_val   = (state == OUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_val && i_rdy) state_nxt = LOAD;
            LOAD: state_nxt = CN;
            // a done arriving alongside its own start pulse belongs to no request yet
            CN:   if (cn_done && !cn_start) state_nxt = VN;
            VN:   if (vn_done && !vn_start) state_nxt = CHK;
            CHK:  state_nxt = last_iter ? OUT : CN;
            OUT:  if (o_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            roop     <= '0;
            o_fail   <= 1'b0;
            cn_start <= 1'b0;
            vn_start <= 1'b0;
        end else begin
            cn_start <= (state_nxt == CN) && (state != CN);
            vn_start <= (state_nxt == VN) && (state != VN);
            if (state == LOAD) begin
                roop <= '0;
            end else if (state == CHK) begin
                roop <= roop_inc;
            end
            if ((state == CHK) && (state_nxt == OUT)) begin
                o_fail <= ~parity;
            end
        end
    end

endmodule
